writeback_buffer: RTL and testbench

- Write-side initiator for the integer register file.
- Collects destination-register writes from two producers: the ALU result path and the load-return path.
- Queues them in a small in-order FIFO and drains one entry per cycle onto the register file's single write port (wr_addr/wr_data/wr_ena).
- Provides combinational bypass of still-queued values to the two read addresses, so decode sees architecturally current operands.

---
 rtl/writeback_buffer_pkg.sv | 18 +
 rtl/wb_fwd_match.sv | 44 ++++
 rtl/writeback_buffer.sv | 120 ++++++++++++
 tb/tb_writeback_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_buffer_pkg.sv
// Shared definitions for the register-file writeback buffer.
//   REG_ADDR_W   : width of an integer register index
//   XLEN_DEFAULT : default register data width
//   ZERO_REG     : architectural x0, never written
//   wb_entry_t   : one queued write {rd, data} at the default width
package writeback_buffer_pkg;

  localparam int REG_ADDR_W   = 5;
  localparam int XLEN_DEFAULT = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0]   rd;
    logic [XLEN_DEFAULT-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match search over the writeback queue for one read address.
// Ports:
//   vld    : per-slot occupied flags
//   rd_q   : per-slot destination register
//   data_q : per-slot write data
//   rd_ptr : slot index of the oldest entry (head)
//   rs     : register being looked up
//   hit    : some occupied slot targets rs (never for x0)
//   val    : data of the youngest matching slot, else 0
module wb_fwd_match
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic [DEPTH-1:0]                 vld,
  input  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q,
  input  logic [DEPTH-1:0][XLEN-1:0]       data_q,
  input  logic [$clog2(DEPTH)-1:0]         rd_ptr,
  input  logic [REG_ADDR_W-1:0]            rs,
  output logic                             hit,
  output logic [XLEN-1:0]                  val
);

  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk slots oldest-to-youngest starting at the head so that the last
  // match seen is the youngest, independent of where the pointers wrapped.
  always_comb begin
    hit = 1'b0;
    val = '0;
    idx = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr + i[PW-1:0];
      if (vld[idx] && (rd_q[idx] == rs) && (rs != ZERO_REG)) begin
        hit = 1'b1;
        val = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/writeback_buffer.sv
// Writeback buffer: merges ALU and load register writes into an in-order
// queue, drains one entry per cycle to the register file write port and
// bypasses still-queued values to two read addresses.
// Ports:
//   clock, reset                 : clock, async active-high reset
//   alu_valid/alu_rd/alu_data    : ALU write request
//   ld_valid/ld_rd/ld_data       : load write request (younger than ALU)
//   in_ready                     : at least two free slots
//   rf_hold                      : register file port busy, freeze head
//   rf_wr_addr/data/ena          : register file write port
//   rs1/rs2                      : read addresses to bypass
//   fwd_hit1/2, fwd_val1/2       : bypass results
//   empty                        : nothing queued
module writeback_buffer
  import writeback_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = XLEN_DEFAULT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  output logic                  in_ready,
  input  logic                  rf_hold,
  output logic [REG_ADDR_W-1:0] rf_wr_addr,
  output logic [XLEN-1:0]       rf_wr_data,
  output logic                  rf_wr_ena,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  fwd_hit1,
  output logic [XLEN-1:0]       fwd_val1,
  output logic                  fwd_hit2,
  output logic [XLEN-1:0]       fwd_val2,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DEPTH-1:0][REG_ADDR_W-1:0] rd_q;
  logic [DEPTH-1:0][XLEN-1:0]       data_q;
  logic [DEPTH-1:0]                 vld_q;
  logic [PW-1:0]                    rd_ptr;
  logic [PW-1:0]                    wr_ptr;
  logic [PW-1:0]                    ld_slot;
  logic [CW-1:0]                    count;
  logic                             alu_acc;
  logic                             ld_acc;

  // Two free slots guarantee both producers fit; independent of valids.
  assign in_ready = (CW'(DEPTH) - count) >= CW'(2);
  assign empty    = (count == '0);

  assign alu_acc  = alu_valid & in_ready & (alu_rd != ZERO_REG);
  assign ld_acc   = ld_valid  & in_ready & (ld_rd  != ZERO_REG);
  // Load lands behind the ALU entry only when the ALU entry was kept.
  assign ld_slot  = wr_ptr + PW'(alu_acc);

  assign rf_wr_ena  = !empty && !rf_hold;
  assign rf_wr_addr = empty ? '0 : rd_q[rd_ptr];
  assign rf_wr_data = empty ? '0 : data_q[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld_q  <= '0;
    end else begin
      // Enqueue only happens with >= 2 free slots, so enqueue slots never
      // coincide with the head slot being released.
      if (rf_wr_ena) begin
        vld_q[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + PW'(1);
      end
      if (alu_acc) vld_q[wr_ptr]  <= 1'b1;
      if (ld_acc)  vld_q[ld_slot] <= 1'b1;
      wr_ptr <= wr_ptr + PW'(alu_acc) + PW'(ld_acc);
      count  <= count + CW'(alu_acc) + CW'(ld_acc) - CW'(rf_wr_ena);
    end
  end

  // Payload storage is qualified by vld_q, so it needs no reset.
  always_ff @(posedge clock) begin
    if (alu_acc) begin
      rd_q[wr_ptr]   <= alu_rd;
      data_q[wr_ptr] <= alu_data;
    end
    if (ld_acc) begin
      rd_q[ld_slot]   <= ld_rd;
      data_q[ld_slot] <= ld_data;
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd1 (
    .vld    (vld_q),
    .rd_q   (rd_q),
    .data_q (data_q),
    .rd_ptr (rd_ptr),
    .rs     (rs1),
    .hit    (fwd_hit1),
    .val    (fwd_val1)
  );

  wb_fwd_match #(.DEPTH(DEPTH), .XLEN(XLEN)) u_fwd2 (
    .vld    (vld_q),
    .rd_q   (rd_q),
    .data_q (data_q),
    .rd_ptr (rd_ptr),
    .rs     (rs2),
    .hit    (fwd_hit2),
    .val    (fwd_val2)
  );

endmodule

// File: tb/tb_writeback_buffer.sv
// Self-checking bench for writeback_buffer: directed vector table,
// hand-written backpressure and reset sequences, and randomized traffic
// checked against a queue-based reference model.
module tb_writeback_buffer;
  import writeback_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clock;
  logic            reset;
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            in_ready;
  logic            rf_hold;
  logic [4:0]      rf_wr_addr;
  logic [XLEN-1:0] rf_wr_data;
  logic            rf_wr_ena;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            fwd_hit1;
  logic [XLEN-1:0] fwd_val1;
  logic            fwd_hit2;
  logic [XLEN-1:0] fwd_val2;
  logic            empty;

  writeback_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock      (clock),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .in_ready   (in_ready),
    .rf_hold    (rf_hold),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .rf_wr_ena  (rf_wr_ena),
    .rs1        (rs1),
    .rs2        (rs2),
    .fwd_hit1   (fwd_hit1),
    .fwd_val1   (fwd_val1),
    .fwd_hit2   (fwd_hit2),
    .fwd_val2   (fwd_val2),
    .empty      (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: queued writes, oldest at index 0.
  wb_entry_t mq[$];

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        hold;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        e_ready;
    logic        e_ena;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_hit1;
    logic [31:0] e_val1;
    logic        e_hit2;
    logic [31:0] e_val2;
    logic        e_empty;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                        input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                        input logic hold, input logic [4:0] r1, input logic [4:0] r2);
    alu_valid = av; alu_rd = ard; alu_data = adat;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ldat;
    rf_hold   = hold; rs1 = r1; rs2 = r2;
  endtask

  // Youngest queued write to rs: {hit, data}.
  function automatic logic [32:0] lookup(input logic [4:0] rs);
    logic [32:0] r;
    bit found;
    r = '0;
    found = 0;
    if (rs != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!found && mq[i].rd == rs) begin
          r = {1'b1, mq[i].data};
          found = 1;
        end
      end
    end
    return r;
  endfunction

  task automatic check_model(input string tag);
    logic [32:0] f1;
    logic [32:0] f2;
    int n;
    n  = mq.size();
    f1 = lookup(rs1);
    f2 = lookup(rs2);
    chk({tag, ".in_ready"}, in_ready, ((DEPTH - n) >= 2) ? 1 : 0);
    chk({tag, ".rf_wr_ena"}, rf_wr_ena, (n > 0 && !rf_hold) ? 1 : 0);
    chk({tag, ".rf_wr_addr"}, rf_wr_addr, (n > 0) ? mq[0].rd : 5'd0);
    chk({tag, ".rf_wr_data"}, rf_wr_data, (n > 0) ? mq[0].data : 32'd0);
    chk({tag, ".fwd_hit1"}, fwd_hit1, f1[32]);
    chk({tag, ".fwd_val1"}, fwd_val1, f1[31:0]);
    chk({tag, ".fwd_hit2"}, fwd_hit2, f2[32]);
    chk({tag, ".fwd_val2"}, fwd_val2, f2[31:0]);
    chk({tag, ".empty"}, empty, (n == 0) ? 1 : 0);
  endtask

  // Apply the spec's edge rules to the model using the inputs present at the edge.
  task automatic model_edge();
    bit rdy;
    rdy = (DEPTH - mq.size()) >= 2;
    if (mq.size() > 0 && !rf_hold) void'(mq.pop_front());
    if (alu_valid && rdy && alu_rd != 5'd0) mq.push_back('{rd: alu_rd, data: alu_data});
    if (ld_valid && rdy && ld_rd != 5'd0) mq.push_back('{rd: ld_rd, data: ld_data});
  endtask

  // Caller sets inputs at posedge+1; outputs sampled mid-cycle.
  task automatic run_cycle(input string tag);
    #4;
    check_model(tag);
    @(posedge clock);
    model_edge();
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{0, 0, 0,            0, 0, 0,            0, 5, 7,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[1]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 5, 7,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[2]  = '{0, 0, 0,            0, 0, 0,            0, 5, 7,  1, 1, 5, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 0,     0};
    vt[3]  = '{0, 0, 0,            0, 0, 0,            0, 5, 7,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[4]  = '{1, 3, 32'h11,       1, 3, 32'h22,       1, 3, 3,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[5]  = '{0, 0, 0,            0, 0, 0,            1, 3, 5,  1, 0, 3, 32'h11,       1, 32'h22,       0, 0,     0};
    vt[6]  = '{0, 0, 0,            0, 0, 0,            0, 3, 3,  1, 1, 3, 32'h11,       1, 32'h22,       1, 32'h22, 0};
    vt[7]  = '{0, 0, 0,            0, 0, 0,            0, 3, 0,  1, 1, 3, 32'h22,       1, 32'h22,       0, 0,     0};
    vt[8]  = '{0, 0, 0,            1, 0, 32'hFFFFFFFF, 0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[9]  = '{0, 0, 0,            0, 0, 0,            0, 0, 0,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[10] = '{0, 0, 0,            1, 9, 32'hAAAA,     0, 9, 0,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[11] = '{0, 0, 0,            0, 0, 0,            0, 9, 0,  1, 1, 9, 32'hAAAA,     1, 32'hAAAA,     0, 0,     0};
    vt[12] = '{0, 0, 0,            0, 0, 0,            0, 9, 0,  1, 0, 0, 0,            0, 0,            0, 0,     1};
    vt[13] = '{1, 0, 32'h55,       1, 12, 32'h66,      0, 12, 12, 1, 0, 0, 0,           0, 0,            0, 0,     1};
    vt[14] = '{0, 0, 0,            0, 0, 0,            0, 12, 12, 1, 1, 12, 32'h66,     1, 32'h66,       1, 32'h66, 0};
    vt[15] = '{0, 0, 0,            0, 0, 0,            0, 12, 12, 1, 0, 0, 0,           0, 0,            0, 0,     1};

    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 5, 7);
    repeat (2) @(posedge clock);
    #1;
    #4;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.empty", empty, 1);
    chk("rst.rf_wr_ena", rf_wr_ena, 0);
    chk("rst.rf_wr_addr", rf_wr_addr, 0);
    chk("rst.rf_wr_data", rf_wr_data, 0);
    chk("rst.fwd_hit1", fwd_hit1, 0);
    chk("rst.fwd_hit2", fwd_hit2, 0);
    chk("rst.fwd_val1", fwd_val1, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    mq.delete();

    // Directed vector table: one row per cycle.
    for (int i = 0; i < 16; i++) begin
      set_in(vt[i].av, vt[i].ard, vt[i].adat, vt[i].lv, vt[i].lrd, vt[i].ldat,
             vt[i].hold, vt[i].r1, vt[i].r2);
      #4;
      chk($sformatf("vec%0d.in_ready", i), in_ready, vt[i].e_ready);
      chk($sformatf("vec%0d.rf_wr_ena", i), rf_wr_ena, vt[i].e_ena);
      chk($sformatf("vec%0d.rf_wr_addr", i), rf_wr_addr, vt[i].e_addr);
      chk($sformatf("vec%0d.rf_wr_data", i), rf_wr_data, vt[i].e_data);
      chk($sformatf("vec%0d.fwd_hit1", i), fwd_hit1, vt[i].e_hit1);
      chk($sformatf("vec%0d.fwd_val1", i), fwd_val1, vt[i].e_val1);
      chk($sformatf("vec%0d.fwd_hit2", i), fwd_hit2, vt[i].e_hit2);
      chk($sformatf("vec%0d.fwd_val2", i), fwd_val2, vt[i].e_val2);
      chk($sformatf("vec%0d.empty", i), empty, vt[i].e_empty);
      @(posedge clock);
      model_edge();
      #1;
    end

    // Backpressure: fill under hold until in_ready falls at three entries.
    for (int k = 1; k <= 4; k++) begin
      set_in(1, 5'(k), 32'h100 + 32'(k), 0, 0, 0, 1, 5'(k), 5'd1);
      run_cycle($sformatf("bp_fill%0d", k));
    end
    set_in(1, 5'd4, 32'h104, 0, 0, 0, 1, 5'd4, 5'd3);
    #4;
    chk("bp.in_ready_low", in_ready, 0);
    chk("bp.held_not_stored", fwd_hit1, 0);
    chk("bp.fwd_val_rd3", fwd_val2, 32'h103);
    @(posedge clock);
    model_edge();
    #1;
    for (int j = 1; j <= 3; j++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
      #4;
      chk($sformatf("bp_drain%0d.ena", j), rf_wr_ena, 1);
      chk($sformatf("bp_drain%0d.addr", j), rf_wr_addr, 5'(j));
      chk($sformatf("bp_drain%0d.data", j), rf_wr_data, 32'h100 + 32'(j));
      chk($sformatf("bp_drain%0d.ready", j), in_ready, (j == 1) ? 0 : 1);
      @(posedge clock);
      model_edge();
      #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    run_cycle("bp_after");

    // Randomized traffic with holds, wrapping the pointers many times.
    for (int c = 0; c < 300; c++) begin
      set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      run_cycle($sformatf("rnd%0d", c));
    end

    // Drain, then queue two entries and reset mid-operation.
    for (int c = 0; c < 6; c++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
      run_cycle("pre_rst_drain");
    end
    set_in(1, 5'd6, 32'h600D, 1, 5'd7, 32'h700D, 1, 5'd6, 5'd7);
    run_cycle("pre_rst_fill");
    set_in(0, 0, 0, 0, 0, 0, 1, 5'd6, 5'd7);
    run_cycle("pre_rst_held");
    chk("pre_rst.queued", mq.size(), 2);
    set_in(0, 0, 0, 0, 0, 0, 0, 5'd6, 5'd7);
    reset = 1'b1;
    #2;
    chk("mid_rst.empty", empty, 1);
    chk("mid_rst.rf_wr_ena", rf_wr_ena, 0);
    chk("mid_rst.in_ready", in_ready, 1);
    chk("mid_rst.fwd_hit1", fwd_hit1, 0);
    chk("mid_rst.fwd_hit2", fwd_hit2, 0);
    mq.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) run_cycle($sformatf("post_rst%0d", c));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
